// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: prescaled PWM LED driver whose colour and duty update only at period boundaries.
// Optional macro RGB_BLINK_EN adds a blink input that blanks the LEDs on alternate 32-period blocks.
module rgb_pwm_driver #(
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r,
    input  logic             g,
    input  logic             b,
    input  logic [CNT_W-1:0] duty,
    input  logic             load,
`ifdef RGB_BLINK_EN
    input  logic             blink,
`endif
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
    output logic             period_start
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PS_W-1:0]  pre;
    logic [CNT_W-1:0] cnt;
    logic             pend_r, pend_g, pend_b;
    logic [CNT_W-1:0] pend_duty;
    logic             act_r, act_g, act_b;
    logic [CNT_W-1:0] act_duty;
    logic             tick;
    logic             wrap;
    logic             pwm_on;
    logic             gate_off;

    assign tick   = (pre == PS_LAST);
    assign wrap   = tick && (cnt == CNT_MAX);
    assign pwm_on = (cnt < act_duty) && !gate_off;

`ifdef RGB_BLINK_EN
    logic [5:0] period_cnt;

    // MSB of the period counter selects the dark half of each 64-period blink cycle
    assign gate_off = blink && period_cnt[5];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (wrap) begin
            period_cnt <= period_cnt + 6'd1;
        end
    end
`else
    assign gate_off = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre <= '0;
            cnt <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A load coinciding with a wrap goes straight to active so it takes effect next period
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_r    <= 1'b0;
            pend_g    <= 1'b0;
            pend_b    <= 1'b0;
            pend_duty <= '0;
            act_r     <= 1'b0;
            act_g     <= 1'b0;
            act_b     <= 1'b0;
            act_duty  <= '0;
        end else begin
            if (load) begin
                pend_r    <= r;
                pend_g    <= g;
                pend_b    <= b;
                pend_duty <= duty;
            end
            if (wrap) begin
                act_r    <= load ? r    : pend_r;
                act_g    <= load ? g    : pend_g;
                act_b    <= load ? b    : pend_b;
                act_duty <= load ? duty : pend_duty;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_r        <= 1'b0;
            led_g        <= 1'b0;
            led_b        <= 1'b0;
            period_start <= 1'b0;
        end else begin
            led_r        <= act_r && pwm_on;
            led_g        <= act_g && pwm_on;
            led_b        <= act_b && pwm_on;
            period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: directed and random checks of rgb_pwm_driver against a cycle-count based model.
// Runs with PRESCALE=3 and blink checks when RGB_BLINK_EN is defined, PRESCALE=1 otherwise.
module tb_rgb_pwm_driver;

    localparam int CNT_W = 4;
`ifdef RGB_BLINK_EN
    localparam int PRESCALE = 3;
`else
    localparam int PRESCALE = 1;
`endif
    localparam int STEPS  = 1 << CNT_W;
    localparam int PERIOD = STEPS * PRESCALE;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             r = 1'b0, g = 1'b0, b = 1'b0, load = 1'b0;
    logic [CNT_W-1:0] duty = '0;
    logic             led_r, led_g, led_b, period_start;
`ifdef RGB_BLINK_EN
    logic             blink = 1'b0;
    logic             s_blink = 1'b0;
`endif

    // Stimulus values held between calls
    logic             s_r = 1'b0, s_g = 1'b0, s_b = 1'b0;
    logic [CNT_W-1:0] s_duty = '0;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: t is the number of clock edges since reset released
    int   t = 0;
    bit   m_pr, m_pg, m_pb, m_ar, m_ag, m_ab;
    int   m_pduty, m_aduty;
    logic [3:0] exp_out;

    rgb_pwm_driver #(.CNT_W(CNT_W), .PRESCALE(PRESCALE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r            (r),
        .g            (g),
        .b            (b),
        .duty         (duty),
        .load         (load),
`ifdef RGB_BLINK_EN
        .blink        (blink),
`endif
        .led_r        (led_r),
        .led_g        (led_g),
        .led_b        (led_b),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelEdge(input logic rstn_i, input logic load_i);
        int  cnt_now;
        bit  wrap_now, gate, on;
        cnt_now  = (t / PRESCALE) % STEPS;
        wrap_now = ((t % PERIOD) == PERIOD - 1);
`ifdef RGB_BLINK_EN
        gate = s_blink && (((t / PERIOD) % 64) >= 32);
`else
        gate = 1'b0;
`endif
        if (!rstn_i) begin
            t = 0;
            {m_pr, m_pg, m_pb, m_ar, m_ag, m_ab} = '0;
            m_pduty = 0;
            m_aduty = 0;
            exp_out = 4'b0000;
        end else begin
            on = (cnt_now < m_aduty) && !gate;
            exp_out = {m_ar && on, m_ag && on, m_ab && on, wrap_now};
            if (wrap_now) begin
                if (load_i) begin
                    {m_ar, m_ag, m_ab} = {s_r, s_g, s_b};
                    m_aduty = int'(s_duty);
                end else begin
                    {m_ar, m_ag, m_ab} = {m_pr, m_pg, m_pb};
                    m_aduty = m_pduty;
                end
            end
            if (load_i) begin
                {m_pr, m_pg, m_pb} = {s_r, s_g, s_b};
                m_pduty = int'(s_duty);
            end
            t++;
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge and compare all outputs
    task automatic applyStimulus(input logic rstn_i, input logic load_i);
        rst_n = rstn_i;
        load  = load_i;
        r     = s_r;
        g     = s_g;
        b     = s_b;
        duty  = s_duty;
`ifdef RGB_BLINK_EN
        blink = s_blink;
`endif
        @(posedge clk);
        modelEdge(rstn_i, load_i);
        #1;
        checkOutput("outputs", int'({led_r, led_g, led_b, period_start}), int'(exp_out));
    endtask

    task automatic loadOnce(input logic lr, input logic lg, input logic lb, input int d);
        s_r = lr;
        s_g = lg;
        s_b = lb;
        s_duty = CNT_W'(d);
        applyStimulus(1'b1, 1'b1);
    endtask

    task automatic waitWrap();
        int n = 0;
        do begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end while (!period_start && n < 2 * PERIOD);
        if (!period_start) checkOutput("wait_wrap_timeout", 0, 1);
    endtask

    // Runs one full period and counts LED high cycles; load_at < 0 means no load
    task automatic countPeriod(input int load_at, output int nr, output int ng, output int nb);
        nr = 0;
        ng = 0;
        nb = 0;
        for (int i = 0; i < PERIOD; i++) begin
            applyStimulus(1'b1, i == load_at);
            nr += int'(led_r);
            ng += int'(led_g);
            nb += int'(led_b);
        end
    endtask

    task automatic firstPulseCheck(input string tag);
        int n = 0;
        do begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end while (!period_start && n < 2 * PERIOD);
        checkOutput(tag, n, PERIOD);
    endtask

    initial begin
        int nr, ng, nb;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("reset_zero", int'({led_r, led_g, led_b, period_start}), 0);
        firstPulseCheck("first_period_start");

        loadOnce(1'b1, 1'b0, 1'b0, 4);
        waitWrap();
        countPeriod(-1, nr, ng, nb);
        checkOutput("basic_r_high", nr, 4 * PRESCALE);
        checkOutput("basic_g_high", ng, 0);
        checkOutput("basic_b_high", nb, 0);

        loadOnce(1'b0, 1'b0, 1'b1, 0);
        waitWrap();
        countPeriod(-1, nr, ng, nb);
        checkOutput("duty0_b_high", nb, 0);
        loadOnce(1'b0, 1'b0, 1'b1, STEPS - 1);
        waitWrap();
        countPeriod(-1, nr, ng, nb);
        checkOutput("dutymax_b_high", nb, (STEPS - 1) * PRESCALE);

        loadOnce(1'b1, 1'b0, 1'b0, 4);
        waitWrap();
        s_duty = CNT_W'(12);
        countPeriod(5 * PRESCALE, nr, ng, nb);
        checkOutput("glitch_old_period", nr, 4 * PRESCALE);
        countPeriod(-1, nr, ng, nb);
        checkOutput("glitch_new_period", nr, 12 * PRESCALE);

        s_duty = CNT_W'(7);
        countPeriod(PERIOD - 1, nr, ng, nb);
        checkOutput("wrap_load_old", nr, 12 * PRESCALE);
        countPeriod(-1, nr, ng, nb);
        checkOutput("wrap_load_new", nr, 7 * PRESCALE);

        waitWrap();
        for (int i = 0; i < 9 * PRESCALE; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("midperiod_reset", int'({led_r, led_g, led_b, period_start}), 0);
        firstPulseCheck("restart_period_start");
        countPeriod(-1, nr, ng, nb);
        checkOutput("after_reset_dark", nr + ng + nb, 0);

`ifdef RGB_BLINK_EN
        applyStimulus(1'b0, 1'b0);
        s_blink = 1'b1;
        loadOnce(1'b1, 1'b1, 1'b1, 8);
        waitWrap();
        begin
            int lit = 0;
            for (int p = 0; p < 64; p++) begin
                countPeriod(-1, nr, ng, nb);
                if (nr != 0) lit++;
            end
            checkOutput("blink_lit_periods", lit, 32);
        end
        s_blink = 1'b0;
`endif

        for (int i = 0; i < 3000; i++) begin
            logic rs, ld;
            rs = ($urandom_range(199) != 0);
            ld = ($urandom_range(5) == 0);
            if (ld) begin
                s_r = 1'($urandom);
                s_g = 1'($urandom);
                s_b = 1'($urandom);
                case ($urandom_range(3))
                    0: s_duty = '0;
                    1: s_duty = '1;
                    default: s_duty = CNT_W'($urandom);
                endcase
            end
`ifdef RGB_BLINK_EN
            if ($urandom_range(499) == 0) s_blink = ~s_blink;
`endif
            applyStimulus(rs, ld);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
